pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 216 +++++++++++++++++++++
 tb/tb_pc_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake, one-entry hold buffer.
// Build with DELAY_SLOT_EN defined to deliver the in-flight/buffered instruction across a redirect.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_addr_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fetch_stall_req
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

`ifdef DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    logic [1:0]  state;
    logic [31:0] pc;
    logic        hold_vld;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic        pend_vld;
    logic [31:0] pend_target;

    logic [1:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic        req_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] if_pc_nxt;
    logic [31:0] if_inst_nxt;
    logic        fsr_nxt;
    logic        hold_vld_nxt;
    logic        pend_vld_nxt;
    logic        hold_load;
    logic        pend_load;

    logic        redirect;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] dlv_pc;
    logic [31:0] dlv_inst;
    logic        issue;
    logic [31:0] issue_addr;

    // redirects only count on cycles the pipeline is moving
    assign redirect = branch_flag_i & ~stall;
    assign target   = word_align(branch_target_addr_i);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        if_pc_nxt    = if_pc;
        if_inst_nxt  = if_inst;
        fsr_nxt      = fetch_stall_req;
        hold_vld_nxt = hold_vld;
        pend_vld_nxt = pend_vld;
        hold_load    = 1'b0;
        pend_load    = 1'b0;
        deliver      = 1'b0;
        dlv_pc       = if_pc;
        dlv_inst     = if_inst;
        issue        = 1'b0;
        issue_addr   = pc;

        case (state)
            IDLE: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (hold_vld) begin
                        // buffer drains on the same edge the next request goes out
                        hold_vld_nxt = 1'b0;
                        deliver      = DELAY_SLOT || !redirect;
                        dlv_pc       = hold_pc;
                        dlv_inst     = hold_inst;
                        if (redirect)
                            issue_addr = target;
                        else if (pend_vld)
                            issue_addr = pend_target;
                        else
                            issue_addr = pc + 32'd4;
                    end else begin
                        if (redirect)
                            issue_addr = target;
                        else if (pend_vld)
                            issue_addr = pend_target;
                        else
                            issue_addr = pc;
                    end
                end
            end

            BUSY: begin
                if (imem_ack) begin
                    if (stall) begin
                        hold_load    = 1'b1;
                        hold_vld_nxt = 1'b1;
                        req_nxt      = 1'b0;
                        state_nxt    = IDLE;
                    end else begin
                        issue    = 1'b1;
                        deliver  = DELAY_SLOT || !redirect;
                        dlv_pc   = imem_addr;
                        dlv_inst = imem_rdata;
                        if (redirect)
                            issue_addr = target;
                        else if (pend_vld)
                            issue_addr = pend_target;
                        else
                            issue_addr = pc + 32'd4;
                    end
                end else if (redirect) begin
                    pend_load    = 1'b1;
                    pend_vld_nxt = 1'b1;
                    if (!DELAY_SLOT)
                        state_nxt = DROP;
                end
            end

            DROP: begin
                if (imem_ack) begin
                    // wrong-path word is discarded; pending target survives a stall
                    if (stall) begin
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = redirect ? target : pend_target;
                    end
                end else if (redirect) begin
                    pend_load    = 1'b1;
                    pend_vld_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase

        if (!stall) begin
            if (deliver) begin
                if_pc_nxt   = dlv_pc;
                if_inst_nxt = dlv_inst;
                fsr_nxt     = 1'b0;
            end else begin
                if_inst_nxt = NOP;
                fsr_nxt     = 1'b1;
            end
        end

        if (issue) begin
            req_nxt      = 1'b1;
            addr_nxt     = issue_addr;
            pc_nxt       = issue_addr;
            state_nxt    = BUSY;
            pend_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            imem_req        <= 1'b0;
            imem_addr       <= 32'h0;
            if_pc           <= 32'h0;
            if_inst         <= 32'h0;
            fetch_stall_req <= 1'b0;
            hold_vld        <= 1'b0;
            pend_vld        <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            imem_req        <= req_nxt;
            imem_addr       <= addr_nxt;
            if_pc           <= if_pc_nxt;
            if_inst         <= if_inst_nxt;
            fetch_stall_req <= fsr_nxt;
            hold_vld        <= hold_vld_nxt;
            pend_vld        <= pend_vld_nxt;
        end
    end

    // payload registers are qualified by hold_vld / pend_vld and need no reset
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_inst <= imem_rdata;
            hold_pc   <= imem_addr;
        end
        if (pend_load)
            pend_target <= target;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; memory returns addr ^ A5A5_0000 as the instruction word.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_addr_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_stall_req;

    int n_chk;
    int n_fail;

    pc_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .branch_flag_i        (branch_flag_i),
        .branch_target_addr_i (branch_target_addr_i),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .if_pc                (if_pc),
        .if_inst              (if_inst),
        .fetch_stall_req      (fetch_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] pc, input logic [31:0] inst, input logic fsr);
        check_eq({tag, ".req"},  {31'b0, imem_req}, {31'b0, req});
        check_eq({tag, ".addr"}, imem_addr, addr);
        check_eq({tag, ".pc"},   if_pc, pc);
        check_eq({tag, ".inst"}, if_inst, inst);
        check_eq({tag, ".fsr"},  {31'b0, fetch_stall_req}, {31'b0, fsr});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b0;
        stall = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_addr_i = 32'h0;
        imem_ack = 1'b0;

        step();
        step();
        check_out("rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // back-to-back fetch with zero-wait memory
        imem_ack = 1'b1;
        rst = 1'b1;
        step();
        check_out("e1", 1'b1, 32'hBFC0_0000, 32'h0, 32'h0, 1'b1);
        step();
        check_out("e2", 1'b1, 32'hBFC0_0004, 32'hBFC0_0000, 32'h1A65_0000, 1'b0);
        step();
        check_out("e3", 1'b1, 32'hBFC0_0008, 32'hBFC0_0004, 32'h1A65_0004, 1'b0);

        // ack delayed three cycles
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("wait", 1'b1, 32'hBFC0_0008, 32'hBFC0_0004, 32'h0, 1'b1);
        end
        imem_ack = 1'b1;
        step();
        check_out("late", 1'b1, 32'hBFC0_000C, 32'hBFC0_0008, inst_of(32'hBFC0_0008), 1'b0);

        // stall on the ack cycle for two cycles
        stall = 1'b1;
        step();
        check_out("stl1", 1'b0, 32'hBFC0_000C, 32'hBFC0_0008, inst_of(32'hBFC0_0008), 1'b0);
        imem_ack = 1'b0;
        step();
        check_out("stl2", 1'b0, 32'hBFC0_000C, 32'hBFC0_0008, inst_of(32'hBFC0_0008), 1'b0);
        stall = 1'b0;
        step();
        check_out("hbuf", 1'b1, 32'hBFC0_0010, 32'hBFC0_000C, inst_of(32'hBFC0_000C), 1'b0);

        // redirect while BFC0_0010 is outstanding; low target bits must be dropped
        branch_flag_i = 1'b1;
        branch_target_addr_i = 32'h8000_0103;
        step();
        check_out("rdw", 1'b1, 32'hBFC0_0010, 32'hBFC0_000C, 32'h0, 1'b1);
        branch_flag_i = 1'b0;
        branch_target_addr_i = 32'h0;
        imem_ack = 1'b1;
        step();
`ifdef DELAY_SLOT_EN
        check_out("dslot", 1'b1, 32'h8000_0100, 32'hBFC0_0010, inst_of(32'hBFC0_0010), 1'b0);
`else
        check_out("drop", 1'b1, 32'h8000_0100, 32'hBFC0_000C, 32'h0, 1'b1);
`endif
        step();
        check_out("tgt", 1'b1, 32'h8000_0104, 32'h8000_0100, inst_of(32'h8000_0100), 1'b0);

        // redirect coincident with ack, target at top of address space
        branch_flag_i = 1'b1;
        branch_target_addr_i = 32'hFFFF_FFFC;
        step();
`ifdef DELAY_SLOT_EN
        check_out("rda", 1'b1, 32'hFFFF_FFFC, 32'h8000_0104, inst_of(32'h8000_0104), 1'b0);
`else
        check_out("rda", 1'b1, 32'hFFFF_FFFC, 32'h8000_0100, 32'h0, 1'b1);
`endif
        branch_flag_i = 1'b0;
        branch_target_addr_i = 32'h0;
        step();
        check_out("wrap", 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1'b0);
        step();
        check_out("wrp2", 1'b1, 32'h0000_0004, 32'h0000_0000, inst_of(32'h0000_0000), 1'b0);

        // asynchronous reset mid-request with ack high
        #2;
        rst = 1'b0;
        #1;
        check_out("arst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        check_out("arst2", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        check_out("rs1", 1'b1, 32'hBFC0_0000, 32'h0, 32'h0, 1'b1);
        step();
        check_out("rs2", 1'b1, 32'hBFC0_0004, 32'hBFC0_0000, 32'h1A65_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
